dtc_vote_window: RTL and testbench

- Downstream stage of the 12-input / 3-bit-class decision-tree classifier.
- Accepts one 3-bit class label per handshake and accumulates a vote histogram over a window of WINDOW labels.
- At the end of each window it emits the majority class through a valid/ready output, then starts a new window.
- Smooths per-sample classifier noise before the result goes to the system interface.

---
 rtl/dtc_pkg.sv | 9 +
 rtl/dtc_argmax_seq.sv | 56 +++++
 rtl/dtc_vote_window.sv | 116 +++++++++++
 tb/tb_dtc_vote_window.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_pkg.sv
// Shared types for the decision-tree classifier vote stage.
package dtc_pkg;
  localparam int CLASS_W = 3;
  localparam int NCLS    = 1 << CLASS_W;

  typedef logic [CLASS_W-1:0] class_t;

  typedef enum logic [1:0] {ACCUM, SCAN, HOLD} vote_state_e;
endpackage

// File: rtl/dtc_argmax_seq.sv
// Sequential argmax over the NCLS histogram bins, one bin per cycle.
// Strictly-greater update keeps the lowest class index on ties.
module dtc_argmax_seq
  import dtc_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] bin_i,
  output class_t           idx_o,
  output logic             done_o,
  output class_t           best_idx_o,
  output logic [CNT_W-1:0] best_cnt_o
);
  logic             busy_q;
  logic             done_q;
  class_t           idx_q;
  class_t           best_idx_q;
  logic [CNT_W-1:0] best_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        busy_q     <= 1'b1;
        idx_q      <= '0;
        best_idx_q <= '0;
        best_cnt_q <= '0;
      end else if (busy_q) begin
        if (bin_i > best_cnt_q) begin
          best_idx_q <= idx_q;
          best_cnt_q <= bin_i;
        end
        if (idx_q == class_t'(NCLS - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          idx_q <= idx_q + class_t'(1);
        end
      end
    end
  end

  assign idx_o      = idx_q;
  assign done_o     = done_q;
  assign best_idx_o = best_idx_q;
  assign best_cnt_o = best_cnt_q;
endmodule

// File: rtl/dtc_vote_window.sv
// Majority vote over a window of WINDOW class labels.
// Define DTC_VOTE_CONF_EN to add out_conf (vote count of the winner).
module dtc_vote_window
  import dtc_pkg::*;
#(
  parameter  int WINDOW = 8,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  class_t           in_class,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef DTC_VOTE_CONF_EN
  output logic [CNT_W-1:0] out_conf,
`endif
  output class_t           out_class
);
  vote_state_e                  state_q;
  logic [NCLS-1:0][CNT_W-1:0]   bins_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [CNT_W-1:0]             cnt_d;
  logic                         in_ready_q;
  logic                         out_valid_q;
  class_t                       out_class_q;

  logic                         accept;
  logic                         last;
  logic                         start;
  class_t                       scan_idx;
  logic                         scan_done;
  class_t                       best_idx;
  logic [CNT_W-1:0]             best_cnt;

  // flush wins over a same-cycle label: the label is dropped
  assign accept = (state_q == ACCUM) && in_valid && !flush;
  assign cnt_d  = cnt_q + CNT_W'(1);
  assign last   = (cnt_d == CNT_W'(WINDOW));
  assign start  = accept && last;

  dtc_argmax_seq #(.CNT_W(CNT_W)) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .bin_i      (bins_q[scan_idx]),
    .idx_o      (scan_idx),
    .done_o     (scan_done),
    .best_idx_o (best_idx),
    .best_cnt_o (best_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      bins_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (flush) begin
            bins_q <= '0;
            cnt_q  <= '0;
          end else if (accept) begin
            bins_q[in_class] <= bins_q[in_class] + CNT_W'(1);
            cnt_q            <= cnt_d;
            if (last) begin
              state_q    <= SCAN;
              in_ready_q <= 1'b0;
            end
          end
        end
        SCAN: begin
          if (scan_done) begin
            out_class_q <= best_idx;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            bins_q      <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

`ifdef DTC_VOTE_CONF_EN
  logic [CNT_W-1:0] out_conf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               out_conf_q <= '0;
    else if (state_q == SCAN && scan_done) out_conf_q <= best_cnt;
  end

  assign out_conf = out_conf_q;
`else
  logic unused_best_cnt;
  assign unused_best_cnt = ^best_cnt;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_class = out_class_q;
endmodule

// File: tb/tb_dtc_vote_window.sv
// Bench for dtc_vote_window: three instances (WINDOW 4, 8, 1), vector table,
// directed corner sequences and a histogram-model scoreboard.
module tb_dtc_vote_window;
  import dtc_pkg::*;

  localparam int WS [3] = '{4, 8, 1};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      vld = '0;
  logic [2:0]      flsh = '0;
  logic [2:0]      ordy_m = '0;
  logic            rnd_on = 1'b0;
  logic            rnd_rdy = 1'b0;
  logic [2:0][2:0] cls = '0;
  logic [2:0]      in_rdy;
  logic [2:0]      ovld;
  logic [2:0][2:0] ocls;
  logic [2:0][7:0] conf;
  wire  [2:0]      ordy_w = ordy_m | (rnd_on ? {1'b0, rnd_rdy, 1'b0} : 3'b000);

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int t_acc = 0;

  typedef struct { int g; int c; int f; } exp_t;
  exp_t exq[$];
  exp_t mon_e;

  int hist [3][8];
  int hcnt [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
`ifdef DTC_VOTE_CONF_EN
    logic [$clog2(WS[g]+1)-1:0] cw;
    assign conf[g] = 8'(cw);
`else
    assign conf[g] = 8'd0;
`endif
    dtc_vote_window #(.WINDOW(WS[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[g]),
      .in_ready  (in_rdy[g]),
      .in_class  (cls[g]),
      .flush     (flsh[g]),
      .out_valid (ovld[g]),
      .out_ready (ordy_w[g]),
`ifdef DTC_VOTE_CONF_EN
      .out_conf  (cw),
`endif
      .out_class (ocls[g])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear(input int g);
    for (int c = 0; c < 8; c++) hist[g][c] = 0;
    hcnt[g] = 0;
  endtask

  task automatic model_accept(input int g, input int c);
    exp_t e;
    int best, bc;
    hist[g][c]++;
    hcnt[g]++;
    if (hcnt[g] == WS[g]) begin
      best = 0; bc = 0;
      for (int k = 0; k < 8; k++)
        if (hist[g][k] > bc) begin best = k; bc = hist[g][k]; end
      e.g = g; e.c = best; e.f = bc;
      exq.push_back(e);
      model_clear(g);
    end
  endtask

  // present one label, hold it until accepted (bounded)
  task automatic send(input int g, input int c, input int idle);
    bit acc, rdy;
    for (int k = 0; k < idle; k++) begin
      vld[g] = 1'b0;
      @(posedge clk); #1;
    end
    vld[g] = 1'b1;
    cls[g] = 3'(c);
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      rdy = in_rdy[g];
      @(posedge clk); #1;
      if (rdy) acc = 1'b1;
    end
    vld[g] = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
    else begin
      t_acc = cyc;
      model_accept(g, c);
    end
  endtask

  task automatic wait_ovld(input int g, output int lat);
    lat = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (ovld[g]) begin
        lat = cyc - t_acc;
        break;
      end
    end
  endtask

  // scoreboard: compare at the sample point before each output handshake
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        if (ovld[g] && ordy_w[g]) begin
          if (exq.size() == 0) chk("sb_unexpected_out", g, -1);
          else begin
            mon_e = exq.pop_front();
            chk("sb_dut", g, mon_e.g);
            chk("sb_class", int'(ocls[g]), mon_e.c);
`ifdef DTC_VOTE_CONF_EN
            chk("sb_conf", int'(conf[g]), mon_e.f);
`endif
          end
        end
      end
    end
  end

  typedef struct { int g; int n; int lab [8]; int ecls; int econf; } vec_t;
  vec_t vt [7];

  initial begin
    int lat;
    bit bad;

    vt[0] = '{g:0, n:4, lab:'{1,1,5,5,0,0,0,0}, ecls:1, econf:2};
    vt[1] = '{g:0, n:4, lab:'{7,6,5,4,0,0,0,0}, ecls:4, econf:1};
    vt[2] = '{g:0, n:4, lab:'{2,3,3,0,0,0,0,0}, ecls:3, econf:2};
    vt[3] = '{g:1, n:8, lab:'{0,0,0,0,0,0,0,0}, ecls:0, econf:8};
    vt[4] = '{g:1, n:8, lab:'{7,7,3,3,3,7,1,1}, ecls:3, econf:3};
    vt[5] = '{g:1, n:8, lab:'{2,6,6,2,6,2,6,5}, ecls:6, econf:4};
    vt[6] = '{g:2, n:1, lab:'{7,0,0,0,0,0,0,0}, ecls:7, econf:1};
    for (int g = 0; g < 3; g++) model_clear(g);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_in_ready", int'(in_rdy[g]), 1);
      chk("rst_out_valid", int'(ovld[g]), 0);
      chk("rst_out_class", int'(ocls[g]), 0);
      chk("rst_out_conf", int'(conf[g]), 0);
    end
    @(posedge clk); #1;

    // vector table, out_ready held high
    ordy_m = 3'b111;
    for (int i = 0; i < 7; i++) begin
      for (int l = 0; l < vt[i].n; l++) send(vt[i].g, vt[i].lab[l], 0);
      wait_ovld(vt[i].g, lat);
      chk("vec_latency", lat, 9);
      chk("vec_class", int'(ocls[vt[i].g]), vt[i].ecls);
`ifdef DTC_VOTE_CONF_EN
      chk("vec_conf", int'(conf[vt[i].g]), vt[i].econf);
`endif
      @(posedge clk); #1;
      @(negedge clk);
      chk("vec_valid_drop", int'(ovld[vt[i].g]), 0);
      chk("vec_ready_back", int'(in_rdy[vt[i].g]), 1);
      @(posedge clk); #1;
    end

    // result held in HOLD while out_ready is low
    ordy_m[0] = 1'b0;
    send(0, 4, 0); send(0, 0, 0); send(0, 4, 0); send(0, 4, 0);
    wait_ovld(0, lat);
    chk("hold_latency", lat, 9);
    bad = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ocls[0] != 3'd4 || !ovld[0] || in_rdy[0]) bad = 1'b1;
    end
    chk("hold_stable", int'(bad), 0);
    @(posedge clk); #1 ordy_m[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_release_valid", int'(ovld[0]), 0);
    chk("hold_release_ready", int'(in_rdy[0]), 1);
    @(posedge clk); #1;

    // flush mid-window drops partial votes and the same-cycle label
    send(1, 7, 0); send(1, 7, 0); send(1, 7, 0);
    flsh[1] = 1'b1; vld[1] = 1'b1; cls[1] = 3'd2;
    @(negedge clk);
    chk("flush_ready_during", int'(in_rdy[1]), 1);
    @(posedge clk); #1;
    flsh[1] = 1'b0; vld[1] = 1'b0;
    model_clear(1);
    @(negedge clk);
    chk("flush_ready_after", int'(in_rdy[1]), 1);
    @(posedge clk); #1;
    for (int l = 0; l < 8; l++) send(1, 6, 0);
    wait_ovld(1, lat);
    chk("flush_class", int'(ocls[1]), 6);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // reset during SCAN loses the pending result
    for (int l = 0; l < 4; l++) send(0, 3, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("scan_in_ready", int'(in_rdy[0]), 0);
    @(posedge clk); #1 rst = 1'b1;
    exq.delete();
    for (int g = 0; g < 3; g++) model_clear(g);
    @(posedge clk); #1 rst = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ovld[0]) bad = 1'b1;
    end
    chk("rst_scan_no_output", int'(bad), 0);
    @(posedge clk); #1;
    for (int l = 0; l < 4; l++) send(0, 2, 0);
    wait_ovld(0, lat);
    chk("rst_scan_next_class", int'(ocls[0]), 2);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // WINDOW=1: each label is its own result, in order
    for (int c = 0; c < 8; c++) send(2, c, 0);
    repeat (15) @(posedge clk);
    #1;

    // random traffic against the histogram model
    ordy_m[1] = 1'b0;
    rnd_on = 1'b1;
    for (int w = 0; w < 1000; w++)
      for (int l = 0; l < 8; l++)
        send(1, (w % 2) ? $urandom_range(0, 7) : $urandom_range(0, 3), $urandom_range(0, 2));
    rnd_on = 1'b0;
    ordy_m[1] = 1'b1;
    for (int k = 0; k < 100 && exq.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", exq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
